cfg_frame_loader: RTL

//  Parses configuration frames from the UART Rx byte stream and loads them into the channel-parameter RAM.

---
 rtl/cfg_pkg.sv | 34 +++
 rtl/cfg_stage_buf.sv | 41 ++++
 rtl/cfg_frame_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-frame loader.
//   - frame marker and parameter-RAM size
//   - FSM state encoding
//   - err_code values
//   - channel record layout inside the parameter RAM. Host tools use it to
//     build frames. The loader itself copies raw bytes and never reads these
//     fields.
package cfg_pkg;

  localparam int         RAM_DEPTH   = 112;
  localparam logic [7:0] SYNC_BYTE   = 8'hAA;
  localparam int         TIMEOUT_CYC = 50000;

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, PAYLOAD, CSUM, COMMIT
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_RANGE   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  // Each channel record is 7 bytes long, so 16 channels fill RAM_DEPTH.
  localparam int REC_STRIDE  = 7;
  localparam int OFS_MODE    = 0;
  localparam int OFS_GAIN    = 1;
  localparam int OFS_OFFSET  = 2;
  localparam int OFS_FREQ_LO = 3;
  localparam int OFS_FREQ_HI = 4;
  localparam int OFS_THRESH  = 5;
  localparam int OFS_FLAGS   = 6;

endpackage

// File: rtl/cfg_stage_buf.sv
// Staging buffer for one frame payload. It is a single-port RAM with a
// synchronous write and a one-cycle registered read.
//   clk_i    clock
//   rst_i    synchronous reset. It clears only the read register.
//   we_i     write enable
//   re_i     read enable. rdata_o updates on the next edge.
//   addr_i   shared read/write index
//   wdata_i  write data
//   rdata_o  registered read data
module cfg_stage_buf
  import cfg_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // The read register drives the RAM data port directly, so it must
  // come out of reset at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cfg_frame_loader.sv
// Loads configuration frames from the UART Rx byte stream into the
// channel-parameter RAM. A frame has the form SYNC, ADDR, LEN, LEN payload
// bytes, CSUM. The payload is staged in a local buffer. It is copied to the
// RAM only after the checksum matches. A bad or aborted frame never touches
// the RAM.
//   clk, rst             clock and synchronous active-high reset
//   rx_data, rx_valid    byte stream from UART Rx (one-cycle strobe)
//   ram_w_addr, ram_in   RAM write address and data
//   ram_write            RAM write strobe, active low
//   busy                 FSM is outside IDLE
//   frame_ok, frame_err  one-cycle completion and discard pulses
//   err_code             cause of the last frame_err, held
module cfg_frame_loader #(
  parameter int         RAM_DEPTH   = cfg_pkg::RAM_DEPTH,
  parameter logic [7:0] SYNC_BYTE   = cfg_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYC = cfg_pkg::TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] ram_w_addr,
  output logic [7:0] ram_in,
  output logic       ram_write,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);
  import cfg_pkg::*;

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d, len_q, len_d, sum_q, sum_d, cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    ram_w_addr_q, ram_w_addr_d;
  logic          ram_write_q, ram_write_d;
  logic          busy_q, frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          buf_we, buf_re, rx_state;
  logic [AW-1:0] buf_addr;
  logic [8:0]    end_addr;

  // cnt_q indexes the payload while it is received. It later indexes the
  // reads during commit, so one address port is enough.
  cfg_stage_buf #(.DEPTH(RAM_DEPTH), .AW(AW)) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (buf_we),
    .re_i    (buf_re),
    .addr_i  (buf_addr),
    .wdata_i (rx_data),
    .rdata_o (ram_in)
  );

  assign rx_state = (state_q inside {ADDR, LEN, PAYLOAD, CSUM});

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    ovr_d        = ovr_q;
    ram_write_d  = 1'b1;
    ram_w_addr_d = ram_w_addr_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    buf_we       = 1'b0;
    buf_re       = 1'b0;
    buf_addr     = cnt_q[AW-1:0];
    end_addr     = {1'b0, addr_q} + {1'b0, rx_data};
    // Counts idle cycles between bytes. Outside the receive states it is held at 0.
    to_d         = (rx_state && !rx_valid) ? to_q + TW'(1) : '0;

    unique case (state_q)
      IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_d = ADDR;
      ADDR:    if (rx_valid) begin
                 addr_d  = rx_data;
                 state_d = LEN;
               end
      LEN:     if (rx_valid) begin
                 len_d = rx_data;
                 sum_d = addr_q + rx_data;
                 cnt_d = '0;
                 // 9-bit compare. Every accepted frame therefore ends inside the RAM.
                 if (rx_data == 8'd0 || end_addr > 9'(RAM_DEPTH)) begin
                   state_d     = IDLE;
                   frame_err_d = 1'b1;
                   err_code_d  = ERR_RANGE;
                 end else begin
                   state_d = PAYLOAD;
                 end
               end
      PAYLOAD: if (rx_valid) begin
                 buf_we = 1'b1;
                 sum_d  = sum_q + rx_data;
                 cnt_d  = cnt_q + 8'd1;
                 if (cnt_q == len_q - 8'd1) state_d = CSUM;
               end
      CSUM:    if (rx_valid) begin
                 cnt_d = '0;
                 ovr_d = 1'b0;
                 if (rx_data == sum_q) begin
                   state_d = COMMIT;
                 end else begin
                   state_d     = IDLE;
                   frame_err_d = 1'b1;
                   err_code_d  = ERR_CSUM;
                 end
               end
      COMMIT:  begin
                 // Bytes arriving now are dropped. The commit still completes.
                 if (rx_valid) begin
                   ovr_d      = 1'b1;
                   err_code_d = ERR_OVERRUN;
                 end
                 // The read is issued in this cycle. It lands in ram_in on the
                 // same edge that registers the strobe and address.
                 if (cnt_q != len_q) begin
                   buf_re       = 1'b1;
                   ram_write_d  = 1'b0;
                   ram_w_addr_d = addr_q + cnt_q;
                   cnt_d        = cnt_q + 8'd1;
                 end else begin
                   state_d     = IDLE;
                   frame_ok_d  = 1'b1;
                   frame_err_d = ovr_q | rx_valid;
                 end
               end
      default: state_d = IDLE;
    endcase

    if (rx_state && !rx_valid && to_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      ovr_q        <= 1'b0;
      ram_write_q  <= 1'b1;
      ram_w_addr_q <= '0;
      busy_q       <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      ovr_q        <= ovr_d;
      ram_write_q  <= ram_write_d;
      ram_w_addr_q <= ram_w_addr_d;
      busy_q       <= (state_d != IDLE);
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign ram_write  = ram_write_q;
  assign ram_w_addr = ram_w_addr_q;
  assign busy       = busy_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule
